// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch/decode slice.
package mips_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [5:0]  OP_J    = 6'b000010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: reset value, sequential increment and redirect load (load wins).
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_inc
);

  // Modulo 2^32: 0xFFFFFFFC wraps to 0.
  assign pc_inc = pc + PC_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc_inc;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: PC, imem req/rdy handshake, registered instr for decode; 1 edge transfer->instrValid.
// decStall holds the output register and drops imemReq in the same cycle; redirects cost 2 cycles.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imemReq,
  output logic [31:0]        imemAddr,
  input  logic               imemRdy,
  input  logic [INSTR_W-1:0] imemData,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opCode,
  output logic [31:0]        pcPlus4,
  output logic               instrValid,
  input  logic               decStall,
  input  logic               jmp,
  input  logic               brTaken,
  input  logic [31:0]        brTarget
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_inc;
  logic [31:0]  target;
  logic         redirect;
  logic         transfer;

  // A taken branch belongs to the older instruction, so it beats a jump.
  assign redirect = brTaken || (jmp && instrValid);
  assign target   = brTaken ? (brTarget & ~32'h3)
                            : {pcPlus4[31:28], instr[25:0], 2'b00};

  assign imemReq  = (state == RUN) && (!instrValid || !decStall) && !redirect;
  assign transfer = imemReq && imemRdy;
  assign imemAddr = pc;
  assign opCode   = instr[31:26];

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (transfer),
    .load   (redirect),
    .target (target),
    .pc     (pc),
    .pc_inc (pc_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= RUN;
        RUN:     state <= redirect ? FLUSH : RUN;
        FLUSH:   state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr      <= '0;
      pcPlus4    <= '0;
      instrValid <= 1'b0;
    end else if (redirect) begin
      instrValid <= 1'b0;
    end else if (transfer) begin
      instr      <= imemData;
      pcPlus4    <= pc_inc;
      instrValid <= 1'b1;
    end else if (instrValid && !decStall) begin
      instrValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: one instance at 0x00400000, one at 0xFFFFFFFC for wrap-around.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemRdy;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic [5:0]  opCode;
  logic [31:0] pcPlus4;
  logic        instrValid;
  logic        decStall;
  logic        jmp;
  logic        brTaken;
  logic [31:0] brTarget;

  logic        rst_n_w;
  logic        imemReq_w;
  logic [31:0] imemAddr_w;
  logic        imemRdy_w;
  logic [31:0] imemData_w;
  logic [31:0] instr_w;
  logic [5:0]  opCode_w;
  logic [31:0] pcPlus4_w;
  logic        instrValid_w;
  logic        decStall_w;
  logic        jmp_w;
  logic        brTaken_w;
  logic [31:0] brTarget_w;

  int total;
  int bad;

  // Memory image: a J at 0x00400004, otherwise lw-opcode words tagged with the address.
  assign imemData   = (imemAddr == 32'h0040_0004) ? 32'h0800_0010 : {6'h23, imemAddr[25:0]};
  assign imemData_w = {6'h23, imemAddr_w[25:0]};

  ifetch_unit #(.RESET_PC(32'h0040_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imemReq(imemReq), .imemAddr(imemAddr), .imemRdy(imemRdy),
    .imemData(imemData), .instr(instr), .opCode(opCode), .pcPlus4(pcPlus4),
    .instrValid(instrValid), .decStall(decStall), .jmp(jmp), .brTaken(brTaken),
    .brTarget(brTarget)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n_w), .imemReq(imemReq_w), .imemAddr(imemAddr_w),
    .imemRdy(imemRdy_w), .imemData(imemData_w), .instr(instr_w), .opCode(opCode_w),
    .pcPlus4(pcPlus4_w), .instrValid(instrValid_w), .decStall(decStall_w), .jmp(jmp_w),
    .brTaken(brTaken_w), .brTarget(brTarget_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imemReq); end
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", instrValid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instr); end
    total++; if (opCode !== 6'h0) begin bad++; $display("FAIL rst_opcode got=%h want=0", opCode); end
    total++; if (pcPlus4 !== 32'h0) begin bad++; $display("FAIL rst_pcplus4 got=%h want=0", pcPlus4); end
    total++; if (imemAddr !== 32'h0040_0000) begin bad++; $display("FAIL rst_addr got=%h want=00400000", imemAddr); end
    rst_n = 1'b1;
    @(negedge clk);  // after E0
    total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL start_req got=%b want=1", imemReq); end
    total++; if (imemAddr !== 32'h0040_0000) begin bad++; $display("FAIL start_addr0 got=%h want=00400000", imemAddr); end
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL start_valid_e0 got=%b want=0", instrValid); end
    @(negedge clk);  // after E1
    total++; if (instrValid !== 1'b1) begin bad++; $display("FAIL start_valid_e1 got=%b want=1", instrValid); end
    total++; if (instr !== 32'h8C40_0000) begin bad++; $display("FAIL start_instr0 got=%h want=8c400000", instr); end
    total++; if (opCode !== 6'h23) begin bad++; $display("FAIL start_op0 got=%h want=23", opCode); end
    total++; if (pcPlus4 !== 32'h0040_0004) begin bad++; $display("FAIL start_pcp4 got=%h want=00400004", pcPlus4); end
    total++; if (imemAddr !== 32'h0040_0004) begin bad++; $display("FAIL start_addr1 got=%h want=00400004", imemAddr); end
    @(negedge clk);  // after E2
    total++; if (imemAddr !== 32'h0040_0008) begin bad++; $display("FAIL start_addr2 got=%h want=00400008", imemAddr); end
    total++; if (instr !== 32'h0800_0010) begin bad++; $display("FAIL start_instr1 got=%h want=08000010", instr); end
    total++; if (opCode !== 6'h02) begin bad++; $display("FAIL start_op1 got=%h want=02", opCode); end
  endtask

  task automatic test_stall();
    decStall = 1'b1;
    #1;
    total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL stall_req got=%b want=0", imemReq); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (instrValid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b want=1", i, instrValid); end
      total++; if (instr !== 32'h0800_0010) begin bad++; $display("FAIL stall_instr[%0d] got=%h want=08000010", i, instr); end
      total++; if (pcPlus4 !== 32'h0040_0008) begin bad++; $display("FAIL stall_pcp4[%0d] got=%h want=00400008", i, pcPlus4); end
      total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%b want=0", i, imemReq); end
    end
    decStall = 1'b0;
    #1;
    total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL unstall_req got=%b want=1", imemReq); end
    total++; if (imemAddr !== 32'h0040_0008) begin bad++; $display("FAIL unstall_addr got=%h want=00400008", imemAddr); end
    @(negedge clk);
    total++; if (instr !== 32'h8C40_0008) begin bad++; $display("FAIL unstall_instr got=%h want=8c400008", instr); end
    total++; if (pcPlus4 !== 32'h0040_000C) begin bad++; $display("FAIL unstall_pcp4 got=%h want=0040000c", pcPlus4); end
  endtask

  task automatic test_jump();
    do_reset();
    repeat (3) @(negedge clk);
    total++; if (instr !== 32'h0800_0010) begin bad++; $display("FAIL jmp_pre_instr got=%h want=08000010", instr); end
    jmp = 1'b1;
    #1;
    total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL jmp_req got=%b want=0", imemReq); end
    @(negedge clk);
    jmp = 1'b0;
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL jmp_valid got=%b want=0", instrValid); end
    total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL jmp_flush_req got=%b want=0", imemReq); end
    total++; if (imemAddr !== 32'h0000_0040) begin bad++; $display("FAIL jmp_addr got=%h want=00000040", imemAddr); end
    @(negedge clk);
    total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL jmp_run_req got=%b want=1", imemReq); end
    total++; if (imemAddr !== 32'h0000_0040) begin bad++; $display("FAIL jmp_run_addr got=%h want=00000040", imemAddr); end
    @(negedge clk);
    total++; if (instr !== 32'h8C00_0040) begin bad++; $display("FAIL jmp_instr got=%h want=8c000040", instr); end
    total++; if (pcPlus4 !== 32'h0000_0044) begin bad++; $display("FAIL jmp_pcp4 got=%h want=00000044", pcPlus4); end
  endtask

  task automatic test_branch_priority();
    brTaken  = 1'b1;
    brTarget = 32'h0040_0103;
    jmp      = 1'b1;
    #1;
    total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL br_req got=%b want=0", imemReq); end
    @(negedge clk);
    brTaken = 1'b0;
    jmp     = 1'b0;
    total++; if (imemAddr !== 32'h0040_0100) begin bad++; $display("FAIL br_addr got=%h want=00400100", imemAddr); end
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL br_valid got=%b want=0", instrValid); end
    total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL br_flush_req got=%b want=0", imemReq); end
    @(negedge clk);
    total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL br_run_req got=%b want=1", imemReq); end
    @(negedge clk);
    total++; if (instr !== 32'h8C40_0100) begin bad++; $display("FAIL br_instr got=%h want=8c400100", instr); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst_n_w = 1'b1;
    @(negedge clk);
    total++; if (imemReq_w !== 1'b1) begin bad++; $display("FAIL wrap_req got=%b want=1", imemReq_w); end
    total++; if (imemAddr_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0 got=%h want=fffffffc", imemAddr_w); end
    @(negedge clk);
    total++; if (imemAddr_w !== 32'h0000_0000) begin bad++; $display("FAIL wrap_addr1 got=%h want=00000000", imemAddr_w); end
    total++; if (pcPlus4_w !== 32'h0000_0000) begin bad++; $display("FAIL wrap_pcp4 got=%h want=00000000", pcPlus4_w); end
    total++; if (instrValid_w !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b want=1", instrValid_w); end
    total++; if (instr_w !== 32'h8FFF_FFFC) begin bad++; $display("FAIL wrap_instr got=%h want=8ffffffc", instr_w); end
    total++; if (opCode_w !== 6'h23) begin bad++; $display("FAIL wrap_op got=%h want=23", opCode_w); end
  endtask

  task automatic test_reset_mid();
    #2;
    total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL mid_pre_req got=%b want=1", imemReq); end
    rst_n = 1'b0;
    #1;
    total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL mid_req got=%b want=0", imemReq); end
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", instrValid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL mid_instr got=%h want=0", instr); end
    total++; if (imemAddr !== 32'h0040_0000) begin bad++; $display("FAIL mid_addr got=%h want=00400000", imemAddr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (imemReq !== 1'b1) begin bad++; $display("FAIL mid_restart_req got=%b want=1", imemReq); end
    total++; if (imemAddr !== 32'h0040_0000) begin bad++; $display("FAIL mid_restart_addr got=%h want=00400000", imemAddr); end
    @(negedge clk);
    total++; if (instr !== 32'h8C40_0000) begin bad++; $display("FAIL mid_restart_instr got=%h want=8c400000", instr); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;   imemRdy = 1'b1;   decStall = 1'b0;   jmp = 1'b0;
    brTaken = 1'b0; brTarget = 32'h0;
    rst_n_w = 1'b0; imemRdy_w = 1'b1; decStall_w = 1'b0; jmp_w = 1'b0;
    brTaken_w = 1'b0; brTarget_w = 32'h0;
    test_reset();
    test_stall();
    test_jump();
    test_branch_priority();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
